// File: rtl/pet_save_pkg.sv
// Shared types and constants for the PET BASIC program saver.
// The file bytes are a 2-byte little-endian load address followed by RAM[start .. end-1].
package pet_save_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PTR   = 2'd1,
        READY = 2'd2,
        FETCH = 2'd3
    } state_e;

    localparam logic [15:0] PTR_TXTTAB = 16'h0028;
    localparam logic [15:0] PTR_VARTAB = 16'h002A;
    localparam int          HDR_LEN    = 2;

    // Body length in bytes: the end pointer is clipped to the top of RAM,
    // and an inverted pair of pointers gives an empty body.
    function automatic logic [15:0] clip_len(input logic [15:0] start_ptr,
                                             input logic [15:0] end_ptr,
                                             input logic [15:0] ram_top);
        logic [15:0] endc;
        endc = (end_ptr > ram_top) ? ram_top : end_ptr;
        return (start_ptr >= endc) ? 16'h0000 : (endc - start_ptr);
    endfunction

endpackage

// File: rtl/prg_saver_dma_rd_seq.sv
// Single RAM read: one dma_rd pulse, then a done strobe in the cycle where dma_dout
// may be sampled, RD_LAT clock edges after the edge that raised dma_rd.
module dma_rd_seq #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        abort_i,
    input  logic        start_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  dma_dout_i,
    output logic [15:0] dma_addr_o,
    output logic        dma_rd_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  data_o
);

    localparam int CW = 4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          rd_q, rd_d;
    logic [15:0]   addr_q, addr_d;

    assign done_o     = busy_q && (cnt_q == CW'(RD_LAT - 1));
    assign busy_o     = busy_q;
    assign dma_rd_o   = rd_q;
    assign dma_addr_o = addr_q;
    assign data_o     = dma_dout_i;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        rd_d   = 1'b0;
        addr_d = addr_q;
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i && !busy_q) begin
            busy_d = 1'b1;
            rd_d   = 1'b1;
            addr_d = addr_i;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (done_o) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= 16'h0000;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            rd_q   <= rd_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/prg_saver.sv
// Serves the PET BASIC program area to hps_io as a .PRG upload, reading the
// BASIC start/end pointers first and then fetching body bytes on demand.
module prg_saver
    import pet_save_pkg::*;
#(
    parameter logic [7:0]  IDX     = 8'h41,
    parameter int          RD_LAT  = 2,
    parameter logic [15:0] RAM_TOP = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_dout,
    output logic [15:0] save_len,
    output logic        len_valid,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        sel, sel_q, sel_rise, sel_fall;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] start_q, start_d;
    logic [7:0]  end_lo_q, end_lo_d;
    logic [15:0] save_len_q, save_len_d;
    logic        len_valid_q, len_valid_d;
    logic        wait_q, wait_d;
    logic [7:0]  din_q, din_d;

    logic        seq_start, seq_busy, seq_done;
    logic [15:0] seq_addr;
    logic [7:0]  seq_data;
    logic [15:0] off;
    logic        past_64k;
    logic [15:0] new_len;

    assign sel      = ioctl_upload && (ioctl_index == IDX);
    assign sel_rise = sel && !sel_q;
    assign sel_fall = !sel && sel_q;
    assign off      = ioctl_addr[15:0];
    assign past_64k = |ioctl_addr[24:16];
    assign new_len  = clip_len(start_q, {seq_data, end_lo_q}, RAM_TOP);

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign save_len   = save_len_q;
    assign len_valid  = len_valid_q;
    assign busy       = (state_q != IDLE);

    dma_rd_seq #(.RD_LAT(RD_LAT)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .abort_i    (sel_fall),
        .start_i    (seq_start),
        .addr_i     (seq_addr),
        .dma_dout_i (dma_dout),
        .dma_addr_o (dma_addr),
        .dma_rd_o   (dma_rd),
        .busy_o     (seq_busy),
        .done_o     (seq_done),
        .data_o     (seq_data)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = start_q;
        end_lo_d    = end_lo_q;
        save_len_d  = save_len_q;
        len_valid_d = len_valid_q;
        wait_d      = wait_q;
        din_d       = din_q;
        seq_start   = 1'b0;
        seq_addr    = 16'h0000;
        if (sel_fall) begin
            state_d     = IDLE;
            wait_d      = 1'b0;
            len_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_rise) begin
                        state_d     = PTR;
                        wait_d      = 1'b1;
                        len_valid_d = 1'b0;
                        idx_d       = 2'd0;
                    end
                end
                PTR: begin
                    if (seq_done) begin
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd0: start_d[7:0]  = seq_data;
                            2'd1: start_d[15:8] = seq_data;
                            2'd2: end_lo_d      = seq_data;
                            default: begin
                                save_len_d  = new_len + 16'(HDR_LEN);
                                len_valid_d = 1'b1;
                                wait_d      = 1'b0;
                                state_d     = READY;
                            end
                        endcase
                    end else if (!seq_busy) begin
                        seq_start = 1'b1;
                        seq_addr  = (idx_q[1] ? PTR_VARTAB : PTR_TXTTAB) + {15'b0, idx_q[0]};
                    end
                end
                READY: begin
                    if (ioctl_rd) begin
                        if (past_64k) begin
                            din_d = 8'h00;
                        end else if (off == 16'd0) begin
                            din_d = start_q[7:0];
                        end else if (off == 16'd1) begin
                            din_d = start_q[15:8];
                        end else if (off < save_len_q) begin
                            seq_start = 1'b1;
                            seq_addr  = start_q + off - 16'(HDR_LEN);
                            wait_d    = 1'b1;
                            state_d   = FETCH;
                        end else begin
                            din_d = 8'h00;
                        end
                    end
                end
                FETCH: begin
                    if (seq_done) begin
                        din_d   = seq_data;
                        wait_d  = 1'b0;
                        state_d = READY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            idx_q       <= 2'd0;
            start_q     <= 16'h0000;
            end_lo_q    <= 8'h00;
            save_len_q  <= 16'h0000;
            len_valid_q <= 1'b0;
            wait_q      <= 1'b0;
            din_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel;
            idx_q       <= idx_d;
            start_q     <= start_d;
            end_lo_q    <= end_lo_d;
            save_len_q  <= save_len_d;
            len_valid_q <= len_valid_d;
            wait_q      <= wait_d;
            din_q       <= din_d;
        end
    end

endmodule

// File: tb/tb_prg_saver.sv
// Directed bench for prg_saver: RAM model behind the DMA port, hps_io-style reads,
// and a scoreboard of expected DMA read addresses.
module tb_prg_saver;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_dout = 8'h00;
    logic [15:0] save_len;
    logic        len_valid;
    logic        busy;

    logic [7:0]  ram [0:65535];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          extra_cnt = 0;
    int          b2b_cnt  = 0;
    logic        prev_rd  = 1'b0;

    prg_saver dut (
        .clk          (clk),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .dma_addr     (dma_addr),
        .dma_rd       (dma_rd),
        .dma_dout     (dma_dout),
        .save_len     (save_len),
        .len_valid    (len_valid),
        .busy         (busy)
    );

    // clock
    always #5 clk = ~clk;

    // RAM: data for a dma_rd appears in the following cycle; junk otherwise
    always @(posedge clk) dma_dout <= dma_rd ? ram[dma_addr] : 8'hEE;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // DMA address scoreboard and pulse-shape monitor
    always @(negedge clk) begin
        if (dma_rd) begin
            if (exp_q.size() > 0) check("dma_addr", 32'(dma_addr), 32'(exp_q.pop_front()));
            else extra_cnt++;
        end
        if (dma_rd && prev_rd) b2b_cnt++;
        prev_rd = dma_rd;
    end

    task automatic start_upload();
        int n;
        exp_q.push_back(16'h0028);
        exp_q.push_back(16'h0029);
        exp_q.push_back(16'h002A);
        exp_q.push_back(16'h002B);
        ioctl_index  = 8'h41;
        ioctl_upload = 1'b1;
        @(negedge clk);
        check("upl_wait_hi", 32'(ioctl_wait), 32'd1);
        check("upl_len_inval", 32'(len_valid), 32'd0);
        n = 0;
        while (ioctl_wait && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("upl_ptr_done", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic stop_upload();
        ioctl_upload = 1'b0;
        @(negedge clk);
        check("stop_busy", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic read_byte(input logic [24:0] a, output logic [7:0] d, output int lat);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        lat = 1;
        while (ioctl_wait && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = ioctl_din;
    endtask

    task automatic rd_check(input string tag, input logic [24:0] a,
                            input logic [7:0] exp_d, input int exp_lat);
        logic [7:0] d;
        int lat;
        read_byte(a, d, lat);
        check({tag, "_data"}, 32'(d), 32'(exp_d));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [7:0] exp_b;
        logic       busy_seen;
        reset = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'h00;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0028] = 8'h01;
        ram[16'h0029] = 8'h04;
        ram[16'h002A] = 8'h10;
        ram[16'h002B] = 8'h04;
        for (int i = 1; i <= 15; i++) ram[16'h0400 + i] = 8'(i);
        ram[16'h7FFF] = 8'hA5;

        repeat (3) @(negedge clk);
        check("rst_din", 32'(ioctl_din), 32'h0);
        check("rst_wait", 32'(ioctl_wait), 32'h0);
        check("rst_dma_rd", 32'(dma_rd), 32'h0);
        check("rst_dma_addr", 32'(dma_addr), 32'h0);
        check("rst_save_len", 32'(save_len), 32'h0);
        check("rst_len_valid", 32'(len_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // start=$0401 end=$0410: 15 body bytes
        start_upload();
        check("s1_save_len", 32'(save_len), 32'd17);
        check("s1_len_valid", 32'(len_valid), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        for (int off = 0; off <= 16; off++) begin
            if (off == 0) exp_b = 8'h01;
            else if (off == 1) exp_b = 8'h04;
            else begin
                exp_b = 8'(off - 1);
                exp_q.push_back(16'h0401 + 16'(off - 2));
            end
            rd_check($sformatf("s1_off%0d", off), 25'(off), exp_b, (off < 2) ? 1 : 3);
        end
        rd_check("s1_past_end", 25'd17, 8'h00, 1);
        rd_check("s1_past_64k", 25'h10000, 8'h00, 1);

        // cycle-level timing of a body read at offset 5
        exp_q.push_back(16'h0404);
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        check("t_wait_t1", 32'(ioctl_wait), 32'd1);
        check("t_dma_rd_t1", 32'(dma_rd), 32'd1);
        check("t_dma_addr_t1", 32'(dma_addr), 32'h0404);
        @(negedge clk);
        check("t_wait_t2", 32'(ioctl_wait), 32'd1);
        check("t_dma_rd_t2", 32'(dma_rd), 32'd0);
        @(negedge clk);
        check("t_wait_t3", 32'(ioctl_wait), 32'd0);
        check("t_din_t3", 32'(ioctl_din), 32'h04);

        // drop the upload while a fetch is in flight
        exp_q.push_back(16'h0405);
        ioctl_addr = 25'd6;
        ioctl_rd   = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        check("drop_in_fetch", 32'(ioctl_wait), 32'd1);
        ioctl_upload = 1'b0;
        @(negedge clk);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_wait", 32'(ioctl_wait), 32'd0);
        check("drop_len_valid", 32'(len_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("drop_discard", 32'(ioctl_din), 32'h04);

        // end=$9000 clipped to $8000; new upload must re-read pointers
        ram[16'h002A] = 8'h00;
        ram[16'h002B] = 8'h90;
        start_upload();
        check("s2_save_len", 32'(save_len), 32'h7C01);
        exp_q.push_back(16'h7FFF);
        rd_check("s2_last", 25'h7C00, 8'hA5, 3);
        rd_check("s2_past_end", 25'h7C01, 8'h00, 1);
        stop_upload();

        // end=$0300 below start: header only
        ram[16'h002B] = 8'h03;
        start_upload();
        check("s3_save_len", 32'(save_len), 32'd2);
        rd_check("s3_off0", 25'd0, 8'h01, 1);
        rd_check("s3_off1", 25'd1, 8'h04, 1);
        rd_check("s3_off2", 25'd2, 8'h00, 1);
        stop_upload();

        // reset in the middle of pointer reads
        exp_q.push_back(16'h0028);
        ioctl_index  = 8'h41;
        ioctl_upload = 1'b1;
        repeat (3) @(negedge clk);
        check("r_busy_in_ptr", 32'(busy), 32'd1);
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        @(negedge clk);
        check("r_din", 32'(ioctl_din), 32'h0);
        check("r_wait", 32'(ioctl_wait), 32'h0);
        check("r_dma_rd", 32'(dma_rd), 32'h0);
        check("r_dma_addr", 32'(dma_addr), 32'h0);
        check("r_save_len", 32'(save_len), 32'h0);
        check("r_len_valid", 32'(len_valid), 32'h0);
        check("r_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // wrong index never starts
        ioctl_index  = 8'h00;
        ioctl_upload = 1'b1;
        busy_seen    = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        check("idx0_busy", 32'(busy_seen), 32'd0);
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk);

        check("dma_pending", 32'(exp_q.size()), 32'd0);
        check("dma_extra", 32'(extra_cnt), 32'd0);
        check("dma_back_to_back", 32'(b2b_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
